// File: rtl/serial_addsub.sv
// Bit-serial add/subtract/complement unit: one full-adder cell reused over
// WIDTH cycles, LSB first, with a start/busy/done handshake and carry/overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start; operands are captured on the accepting edge
  // RUN   | one bit per edge through the adder cell, LSB first
  // DONE  | one-cycle done pulse; result/cout/ovf already valid
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_sh, y_sh, x_init, y_init;
  logic [CNT_W-1:0] cnt;
  logic             carry, cin0, s_bit, c_bit, last_bit;

  always_comb begin
    x_init = a;
    y_init = b;
    cin0   = 1'b0;
    case (mode)
      2'b00: begin x_init = a;  y_init = b;       cin0 = 1'b0; end
      2'b01: begin x_init = a;  y_init = ~b;      cin0 = 1'b1; end
      2'b10: begin x_init = ~a; y_init = '0;      cin0 = 1'b0; end
      default: begin x_init = ~a; y_init = '0;    cin0 = 1'b1; end
    endcase
  end

  assign s_bit    = x_sh[0] ^ y_sh[0] ^ carry;
  assign c_bit    = (x_sh[0] & y_sh[0]) | (carry & (x_sh[0] ^ y_sh[0]));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits shift into the MSB end of the x register as x bits are consumed,
  // so after WIDTH shifts x_sh holds the sum; no separate sum register needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_sh   <= '0;
      y_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      x_sh  <= x_init;
      y_sh  <= y_init;
      carry <= cin0;
      cnt   <= '0;
    end else if (state == RUN) begin
      x_sh  <= {s_bit, x_sh[WIDTH-1:1]};
      y_sh  <= {1'b0, y_sh[WIDTH-1:1]};
      carry <= c_bit;
      if (last_bit) begin
        result <= {s_bit, x_sh[WIDTH-1:1]};
        cout   <= c_bit;
        ovf    <= carry ^ c_bit;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=4, 8 and 16 against an
// arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 0, busy8, done8, cout8, ovf8;
  logic [1:0]  mode8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic        start4 = 0, busy4, done4, cout4, ovf4;
  logic [1:0]  mode4 = 0;
  logic [3:0]  a4 = 0, b4 = 0, res4;
  logic        start16 = 0, busy16, done16, cout16, ovf16;
  logic [1:0]  mode16 = 0;
  logic [15:0] a16 = 0, b16 = 0, res16;

  int total = 0;
  int bad = 0;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8));
  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4));
  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .cout(cout16), .ovf(ovf16));

  // Reference: x + y + cin as plain integers; overflow = carry into MSB ^ carry out.
  function automatic void ref_op(input int w, input int m, input int av, input int bv,
                                 output int r, output bit co, output bit ov);
    int mask, low, x, y, cin, s, cm;
    mask = (1 << w) - 1;
    low  = (1 << (w - 1)) - 1;
    x    = (m >= 2) ? (~av & mask) : (av & mask);
    y    = (m == 0) ? (bv & mask) : (m == 1) ? (~bv & mask) : 0;
    cin  = (m == 1 || m == 3) ? 1 : 0;
    s    = x + y + cin;
    r    = s & mask;
    co   = ((s >> w) & 1) != 0;
    cm   = (((x & low) + (y & low) + cin) >> (w - 1)) & 1;
    ov   = co ^ (cm != 0);
  endfunction

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] m,
                      output int lat, output int bcnt);
    a8 = av; b8 = bv; mode8 = m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    bcnt = busy8 ? 1 : 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (busy8) bcnt++;
      if (done8) begin lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic [1:0] m,
                      output int lat);
    a4 = av; b4 = bv; mode4 = m; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done4) begin lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] m,
                       output int lat);
    a16 = av; b16 = bv; mode16 = m; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done16) begin lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if ({busy8, done8, res8, cout8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL reset8 got busy=%b done=%b res=%h cout=%b ovf=%b want all 0",
                      busy8, done8, res8, cout8, ovf8);
    end
    total++;
    if ({busy4, done4, res4, busy16, done16, res16} !== 24'h0) begin
      bad++; $display("FAIL reset4_16 got res4=%h res16=%h busy=%b%b want 0", res4, res16, busy4, busy16);
    end
  endtask

  task automatic test_add();
    int lat, bcnt;
    run8(8'h64, 8'h37, 2'b00, lat, bcnt);
    total++;
    if ({res8, cout8, ovf8} !== {8'h9B, 1'b0, 1'b1}) begin
      bad++; $display("FAIL add got res=%h cout=%b ovf=%b want 9b 0 1", res8, cout8, ovf8);
    end
    total++;
    if (lat != 8) begin bad++; $display("FAIL add_latency got %0d want 8", lat); end
    total++;
    if (bcnt != 9) begin bad++; $display("FAIL add_busy got %0d want 9", bcnt); end
  endtask

  task automatic test_sub();
    int lat, bcnt;
    run8(8'h05, 8'h07, 2'b01, lat, bcnt);
    total++;
    if ({res8, cout8, ovf8} !== {8'hFE, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sub_borrow got res=%h cout=%b ovf=%b want fe 0 0", res8, cout8, ovf8);
    end
    run8(8'h80, 8'h01, 2'b01, lat, bcnt);
    total++;
    if ({res8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++; $display("FAIL sub_ovf got res=%h cout=%b ovf=%b want 7f 1 1", res8, cout8, ovf8);
    end
  endtask

  task automatic test_complement();
    int lat, bcnt;
    run8(8'h5A, 8'hFF, 2'b10, lat, bcnt);
    total++;
    if ({res8, cout8, ovf8} !== {8'hA5, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ones_comp got res=%h cout=%b ovf=%b want a5 0 0", res8, cout8, ovf8);
    end
    run8(8'h00, 8'h33, 2'b11, lat, bcnt);
    total++;
    if ({res8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL twos_zero got res=%h cout=%b ovf=%b want 00 1 0", res8, cout8, ovf8);
    end
    run8(8'h80, 8'h00, 2'b11, lat, bcnt);
    total++;
    if ({res8, ovf8} !== {8'h80, 1'b1}) begin
      bad++; $display("FAIL twos_min got res=%h ovf=%b want 80 1", res8, ovf8);
    end
  endtask

  task automatic test_random8();
    int lat, bcnt, r;
    bit co, ov;
    logic [7:0] av, bv;
    logic [1:0] m;
    for (int n = 0; n < 40; n++) begin
      av = 8'($urandom); bv = 8'($urandom); m = 2'($urandom_range(0, 3));
      ref_op(8, int'(m), int'(av), int'(bv), r, co, ov);
      run8(av, bv, m, lat, bcnt);
      total++;
      if ({res8, cout8, ovf8} !== {8'(r), co, ov} || lat != 8) begin
        bad++; $display("FAIL rand8 m=%0d a=%h b=%h got %h/%b/%b lat=%0d want %h/%b/%b lat=8",
                        m, av, bv, res8, cout8, ovf8, lat, 8'(r), co, ov);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    bit extra;
    a8 = 8'h10; b8 = 8'h20; mode8 = 2'b00; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 a8 = 8'h77; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i + 4; break; end
    end
    total++;
    if (res8 !== 8'h30 || lat != 8) begin
      bad++; $display("FAIL ignore_start got res=%h lat=%0d want 30 lat=8", res8, lat);
    end
    extra = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin bad++; $display("FAIL start_queued got extra done=%b want 0", extra); end
  endtask

  task automatic test_midrun_change();
    int lat, r;
    bit co, ov;
    ref_op(8, 1, 8'h3C, 8'h11, r, co, ov);
    a8 = 8'h3C; b8 = 8'h11; mode8 = 2'b01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom);
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    @(posedge clk); #1;
    total++;
    if ({res8, cout8, ovf8} !== {8'(r), co, ov} || lat != 8) begin
      bad++; $display("FAIL midrun_change got %h/%b/%b lat=%0d want %h/%b/%b lat=8",
                      res8, cout8, ovf8, lat, 8'(r), co, ov);
    end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int nd, cyc;
    nd = 0;
    cyc = 0;
    a8 = 8'h01; b8 = 8'h02; mode8 = 2'b00; start8 = 1'b1;
    while (nd < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) begin
        t[nd] = cyc;
        if (nd == 0) begin
          total++;
          if (res8 !== 8'h03) begin bad++; $display("FAIL b2b_first got %h want 03", res8); end
          a8 = 8'h05;
        end else if (nd == 1) begin
          total++;
          if (res8 !== 8'h07) begin bad++; $display("FAIL b2b_resample got %h want 07", res8); end
        end
        nd++;
      end
    end
    start8 = 1'b0;
    total++;
    if (nd != 3 || t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
      bad++; $display("FAIL b2b_period got dones=%0d gaps=%0d,%0d want 3 dones gaps 10,10",
                      nd, t[1] - t[0], t[2] - t[1]);
    end
    for (int i = 0; i < 30 && busy8; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_midrun();
    bit extra;
    a8 = 8'h12; b8 = 8'h34; mode8 = 2'b00; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({busy8, done8, res8} !== 10'h0) begin
      bad++; $display("FAIL reset_midrun got busy=%b done=%b res=%h want 0 0 00", busy8, done8, res8);
    end
    extra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin bad++; $display("FAIL reset_abandon got activity=%b want 0", extra); end
  endtask

  task automatic test_width4();
    int lat, r;
    bit co, ov;
    logic [3:0] av, bv;
    logic [1:0] m;
    run4(4'hF, 4'h1, 2'b00, lat);
    total++;
    if ({res4, cout4, ovf4} !== {4'h0, 1'b1, 1'b0} || lat != 4) begin
      bad++; $display("FAIL w4_wrap got res=%h cout=%b ovf=%b lat=%0d want 0 1 0 lat=4",
                      res4, cout4, ovf4, lat);
    end
    for (int n = 0; n < 20; n++) begin
      av = 4'($urandom); bv = 4'($urandom); m = 2'($urandom_range(0, 3));
      ref_op(4, int'(m), int'(av), int'(bv), r, co, ov);
      run4(av, bv, m, lat);
      total++;
      if ({res4, cout4, ovf4} !== {4'(r), co, ov} || lat != 4) begin
        bad++; $display("FAIL rand4 m=%0d a=%h b=%h got %h/%b/%b lat=%0d want %h/%b/%b lat=4",
                        m, av, bv, res4, cout4, ovf4, lat, 4'(r), co, ov);
      end
    end
  endtask

  task automatic test_width16_random();
    int lat, r;
    bit co, ov;
    logic [15:0] av, bv;
    logic [1:0] m;
    for (int n = 0; n < 1000; n++) begin
      av = 16'($urandom); bv = 16'($urandom); m = 2'($urandom_range(0, 1));
      ref_op(16, int'(m), int'(av), int'(bv), r, co, ov);
      run16(av, bv, m, lat);
      total++;
      if ({res16, cout16, ovf16} !== {16'(r), co, ov} || lat != 16) begin
        bad++; $display("FAIL rand16 m=%0d a=%h b=%h got %h/%b/%b lat=%0d want %h/%b/%b lat=16",
                        m, av, bv, res16, cout16, ovf16, lat, 16'(r), co, ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_complement();
    test_random8();
    test_ignore_start();
    test_midrun_change();
    test_back_to_back();
    test_reset_midrun();
    test_width4();
    test_width16_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, bit-serial arithmetic unit. It reuses one full-adder cell over WIDTH clock cycles, LSB first.
- Modes: add, subtract, ones' complement and two's complement.
- Generalises the board-level half-subtractor and complement logic to any operand width.
- Adds a start/busy/done handshake, carry/borrow flags and signed-overflow flags.
- Sits between the switch-input register and the LED/result display logic.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request an operation; sampled only when busy=0.
- mode, input, 2, operation select: 00 A+B, 01 A−B, 10 ~A (ones' complement), 11 −A (two's complement).
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B; ignored in modes 10/11.
- busy, output, 1, high while an operation is in progress (states RUN and DONE).
- done, output, 1, one-cycle pulse; result and flags are valid from this cycle.
- result, output, WIDTH, registered result.
- cout, output, 1, final carry out. In mode 01, 1 means no borrow.
- ovf, output, 1, signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0.
  - Internal shift registers, carry and counter cleared.
  - Reset mid-operation abandons the operation; nothing is written to result.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch a, b and mode, set counter=0, and go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge processes bit[counter] through the full-adder cell, shifts in the sum bit and updates the carry register. When counter==WIDTH−1, go to DONE; otherwise counter+1.
  - DONE: busy=1, done=1 for exactly this one cycle. Next edge goes to IDLE.
- Operand mapping per mode:
  - 00: x=a, y=b, cin0=0.
  - 01: x=a, y=~b, cin0=1.
  - 10: x=~a, y=0, cin0=0.
  - 11: x=~a, y=0, cin0=1.
- Carry register is loaded with cin0 on accept.
- On the edge entering DONE:
  - result, cout and ovf are written from the complete sum, the final carry and the saved MSB carry-in.
  - These outputs hold until the next entry to DONE or reset.
- Timing:
  - done rises WIDTH edges after the accepting edge.
  - Earliest next accept is 2 edges after that, so sustained throughput is one operation per WIDTH+2 cycles.
- Input handling:
  - start while busy=1 (RUN or DONE) is ignored; it is not queued.
  - a, b and mode changes after acceptance have no effect on the current operation.
  - start held high continuously gives back-to-back operations, each re-sampling a, b and mode in IDLE.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Add, WIDTH=8, mode=00, a=0x64, b=0x37, start pulse:
  - busy high for 9 cycles;
  - done at edge 8 after accept;
  - result=0x9B, cout=0, ovf=1.
- Subtract, mode=01:
  - a=0x05, b=0x07 → result=0xFE, cout=0 (borrow), ovf=0.
  - Then a=0x80, b=0x01 → result=0x7F, cout=1, ovf=1.
- Complement modes:
  - mode=10, a=0x5A → result=0xA5, cout=0, ovf=0.
  - mode=11, a=0x00 → result=0x00, cout=1, ovf=0.
  - mode=11, a=0x80 → result=0x80, ovf=1.
- Handshake:
  - Pulse start again 3 cycles after accept with different a → ignored; original result is delivered.
  - Change a/b mid-RUN → no effect.
  - Hold start high → done pulses every 10 cycles.
- Reset:
  - rst_n=0 for one edge at counter=4 → busy=0, done=0, result=0 on the next cycle.
  - No done pulse follows until a new start.
- Parameter sweep:
  - WIDTH=4: mode=00, a=0xF, b=0x1 → result=0x0, cout=1, ovf=0, done 4 edges after accept.
  - WIDTH=16: random add/sub compared against a reference model over 1000 operations.
